mips_exec_decode: RTL and testbench
===================================

MIPS_EXEC_DECODE -- requirements
Module: mips_exec_decode

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 in_valid  input  1  opcode/funct/a/b are valid this cycle.
REQ-004 opcode  input  6  instruction bits [31:26].
REQ-005 funct  input  6  instruction bits [5:0].
REQ-006 a  input  32  ALU operand A (rs value, already forwarded).
REQ-007 b  input  32  ALU operand B (rt value or sign-extended immediate, already muxed).
REQ-008 out_valid  output  1  registered copy of in_valid.
REQ-009 regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, alusrc, regwrite, jump  output  1 each  registered decode flags.
REQ-010 aluop  output  2  registered ALU-op class: 00 add, 01 sub, 10 funct-decoded, 11 unused.
REQ-011 aluctl  output  6  registered ALU control code.
REQ-012 result  output  32  registered ALU result.
REQ-013 zero  output  1  registered (result == 0).
REQ-014 overflow  output  1  registered signed overflow flag.

Function
REQ-015 Decode: R-type 000000 -> regdst, regwrite, aluop=10.
REQ-016 Decode: lw 100011 -> memread, memtoreg, alusrc, regwrite, aluop=00.
REQ-017 Decode: sw 101011 -> memwrite, alusrc, aluop=00.
REQ-018 Decode: beq 000100 -> branch_eq, aluop=01; bne 000101 -> branch_ne, aluop=01.
REQ-019 Decode: addi 001000 -> alusrc, regwrite, aluop=00; j 000010 -> jump only.
REQ-020 Any other opcode SHALL drive every decode flag and aluop to 0.
REQ-021 aluctl from aluop: 00 -> ADD(2); 01 -> SUB(6); 11 -> AND(0).
REQ-022 aluctl for aluop=10, by funct: 100000 ADD(2), 100010 SUB(6), 100100 AND(0), 100101 OR(1), 100111 NOR(12), 101010 SLT(7), 100110 XOR(13); any other funct -> AND(0).
REQ-023 ALU ops: AND a&b; OR a|b; ADD a+b mod 2^32; SUB a-b mod 2^32; NOR ~(a|b); XOR a^b; SLT 1 if signed a<b else 0 (correct across overflow).
REQ-024 Any unlisted aluctl value SHALL yield result 0.
REQ-025 overflow SHALL be 1 only for ADD/SUB with signed overflow; 0 for all other ops.
REQ-026 Latency is exactly 1 cycle: outputs at edge N+1 reflect inputs sampled at edge N.
REQ-027 With in_valid=0, out_valid SHALL be 0 next cycle; all other outputs SHALL hold their previous values.
REQ-028 No backpressure: every valid input is accepted each cycle; back-to-back valids produce back-to-back results.

Reset
REQ-029 With reset_n=0 at a rising edge, every output SHALL become 0, including out_valid and zero; reset overrides in_valid.
REQ-030 A transaction sampled in the same cycle as reset SHALL be discarded; reset mid-stream leaves no stale out_valid.
REQ-031 The first valid input after reset_n returns high SHALL produce its result one cycle later.

Structure
REQ-032 A shared package mips_pkg SHALL hold opcode constants, funct constants, the aluop encoding and the 6-bit aluctl codes.
REQ-033 The combinational datapath SHALL be one sub-module, alu_core (a, b, aluctl -> result, overflow); decode and the output register live in the top.

Verification
REQ-034 R-type add, a=5, b=7 -> next cycle: result=12, zero=0, regdst=1, regwrite=1, aluop=10, aluctl=2.
REQ-035 beq, a=b=0x1234 -> aluctl=6, result=0, zero=1, branch_eq=1.
REQ-036 SLT, a=0xFFFFFFFF, b=1 -> result=1; a=0x7FFFFFFF, b=0x80000000 -> result=0.
REQ-037 ADD, a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1; lw opcode -> memread, memtoreg, alusrc, regwrite=1.
REQ-038 Opcode 111111 -> all decode flags 0, aluop=00, aluctl=2.
REQ-039 Valid inputs in 3 consecutive cycles with reset_n=0 in cycle 2 -> cycle-3 outputs all 0; cycle-4 shows only the 3rd result.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared decode constants for the execute/decode stage: opcodes, functs,
// ALU-op classes, ALU control codes and the opcode/aluctl decode helpers.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_SUB    = 2'b01,
    ALUOP_FUNCT  = 2'b10,
    ALUOP_UNUSED = 2'b11
  } aluop_e;

  localparam logic [5:0] ALUCTL_AND = 6'd0;
  localparam logic [5:0] ALUCTL_OR  = 6'd1;
  localparam logic [5:0] ALUCTL_ADD = 6'd2;
  localparam logic [5:0] ALUCTL_SUB = 6'd6;
  localparam logic [5:0] ALUCTL_SLT = 6'd7;
  localparam logic [5:0] ALUCTL_NOR = 6'd12;
  localparam logic [5:0] ALUCTL_XOR = 6'd13;

  typedef struct packed {
    logic   regdst;
    logic   branch_eq;
    logic   branch_ne;
    logic   memread;
    logic   memwrite;
    logic   memtoreg;
    logic   alusrc;
    logic   regwrite;
    logic   jump;
    aluop_e aluop;
  } ctrl_t;

  // Main control: unknown opcodes fall through with every flag clear and aluop=ADD.
  function automatic ctrl_t decode_opcode(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        c.aluop    = ALUOP_FUNCT;
      end
      OP_LW: begin
        c.memread  = 1'b1;
        c.memtoreg = 1'b1;
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
      end
      OP_SW: begin
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
      end
      OP_BEQ: begin
        c.branch_eq = 1'b1;
        c.aluop     = ALUOP_SUB;
      end
      OP_BNE: begin
        c.branch_ne = 1'b1;
        c.aluop     = ALUOP_SUB;
      end
      OP_ADDI: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
      end
      OP_J: c.jump = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // ALU control: aluop class first, funct only consulted for R-type.
  function automatic logic [5:0] alu_control(input aluop_e aluop, input logic [5:0] funct);
    logic [5:0] ctl;
    ctl = ALUCTL_AND;
    case (aluop)
      ALUOP_ADD: ctl = ALUCTL_ADD;
      ALUOP_SUB: ctl = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  ctl = ALUCTL_ADD;
          FN_SUB:  ctl = ALUCTL_SUB;
          FN_AND:  ctl = ALUCTL_AND;
          FN_OR:   ctl = ALUCTL_OR;
          FN_NOR:  ctl = ALUCTL_NOR;
          FN_SLT:  ctl = ALUCTL_SLT;
          FN_XOR:  ctl = ALUCTL_XOR;
          default: ctl = ALUCTL_AND;
        endcase
      end
      default: ctl = ALUCTL_AND;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU: logic ops, add/sub with signed overflow, signed SLT.
module alu_core
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [5:0]  aluctl,
  output logic [31:0] result,
  output logic        overflow
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic        less;

  assign sum  = a + b;
  assign diff = a - b;

  // Overflow when operand signs make the true result unrepresentable.
  assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
  assign sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);

  // With differing signs the negative operand is smaller; otherwise diff cannot overflow.
  assign less = (a[31] != b[31]) ? a[31] : diff[31];

  // Select the operation result and its overflow flag.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (aluctl)
      ALUCTL_AND: result = a & b;
      ALUCTL_OR:  result = a | b;
      ALUCTL_ADD: begin
        result   = sum;
        overflow = add_ovf;
      end
      ALUCTL_SUB: begin
        result   = diff;
        overflow = sub_ovf;
      end
      ALUCTL_SLT: result = {31'd0, less};
      ALUCTL_NOR: result = ~(a | b);
      ALUCTL_XOR: result = a ^ b;
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_exec_decode.sv
// Single-cycle decode + execute stage with one output register; idle cycles
// hold the last result and only drop out_valid.
module mips_exec_decode
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic        regdst,
  output logic        branch_eq,
  output logic        branch_ne,
  output logic        memread,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        alusrc,
  output logic        regwrite,
  output logic        jump,
  output logic [1:0]  aluop,
  output logic [5:0]  aluctl,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow
);

  ctrl_t       ctrl;
  logic [5:0]  aluctl_d;
  logic [31:0] result_d;
  logic        overflow_d;

  // Decode the opcode and derive the ALU control code.
  always_comb begin
    ctrl     = decode_opcode(opcode);
    aluctl_d = alu_control(ctrl.aluop, funct);
  end

  alu_core u_alu (
    .a        (a),
    .b        (b),
    .aluctl   (aluctl_d),
    .result   (result_d),
    .overflow (overflow_d)
  );

  // Output register: reset clears all, valid loads, idle holds everything but out_valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      regdst    <= 1'b0;
      branch_eq <= 1'b0;
      branch_ne <= 1'b0;
      memread   <= 1'b0;
      memwrite  <= 1'b0;
      memtoreg  <= 1'b0;
      alusrc    <= 1'b0;
      regwrite  <= 1'b0;
      jump      <= 1'b0;
      aluop     <= 2'b00;
      aluctl    <= 6'd0;
      result    <= 32'd0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        regdst    <= ctrl.regdst;
        branch_eq <= ctrl.branch_eq;
        branch_ne <= ctrl.branch_ne;
        memread   <= ctrl.memread;
        memwrite  <= ctrl.memwrite;
        memtoreg  <= ctrl.memtoreg;
        alusrc    <= ctrl.alusrc;
        regwrite  <= ctrl.regwrite;
        jump      <= ctrl.jump;
        aluop     <= ctrl.aluop;
        aluctl    <= aluctl_d;
        result    <= result_d;
        zero      <= (result_d == 32'd0);
        overflow  <= overflow_d;
      end
    end
  end

endmodule

// File: tb/tb_mips_exec_decode.sv
// Scoreboard bench: an expected output snapshot is queued for every driven
// cycle and compared one clock later against the registered outputs.
module tb_mips_exec_decode;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid, regdst, branch_eq, branch_ne, memread, memwrite;
  logic        memtoreg, alusrc, regwrite, jump, zero, overflow;
  logic [1:0]  aluop;
  logic [5:0]  aluctl;
  logic [31:0] result;

  typedef struct packed {
    logic        out_valid;
    logic [8:0]  flags;
    logic [1:0]  aluop;
    logic [5:0]  aluctl;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
  } exp_t;

  exp_t sb[$];
  exp_t model_q;
  int   n_cmp = 0;
  int   n_err = 0;

  mips_exec_decode dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .opcode(opcode),
    .funct(funct), .a(a), .b(b), .out_valid(out_valid), .regdst(regdst),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg), .alusrc(alusrc),
    .regwrite(regwrite), .jump(jump), .aluop(aluop), .aluctl(aluctl),
    .result(result), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: wide signed arithmetic for overflow and SLT.
  function automatic exp_t model(input exp_t prev, input logic rst_n, input logic v,
                                 input logic [5:0] op, input logic [5:0] fn,
                                 input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sx, sy, r;
    e = prev;
    if (!rst_n) return '0;
    e.out_valid = v;
    if (!v) return e;
    e.flags = 9'b0;
    e.aluop = 2'b00;
    case (op)
      6'b000000: begin e.flags = 9'b100000010; e.aluop = 2'b10; end
      6'b100011: e.flags = 9'b000101110;
      6'b101011: e.flags = 9'b000010100;
      6'b000100: begin e.flags = 9'b010000000; e.aluop = 2'b01; end
      6'b000101: begin e.flags = 9'b001000000; e.aluop = 2'b01; end
      6'b001000: e.flags = 9'b000000110;
      6'b000010: e.flags = 9'b000000001;
      default:   e.flags = 9'b0;
    endcase
    if (e.aluop == 2'b00) e.aluctl = 6'd2;
    else if (e.aluop == 2'b01) e.aluctl = 6'd6;
    else begin
      case (fn)
        6'h20:   e.aluctl = 6'd2;
        6'h22:   e.aluctl = 6'd6;
        6'h24:   e.aluctl = 6'd0;
        6'h25:   e.aluctl = 6'd1;
        6'h27:   e.aluctl = 6'd12;
        6'h2a:   e.aluctl = 6'd7;
        6'h26:   e.aluctl = 6'd13;
        default: e.aluctl = 6'd0;
      endcase
    end
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.overflow = 1'b0;
    case (e.aluctl)
      6'd0:  e.result = x & y;
      6'd1:  e.result = x | y;
      6'd12: e.result = ~(x | y);
      6'd13: e.result = x ^ y;
      6'd7:  e.result = (sx < sy) ? 32'd1 : 32'd0;
      6'd2, 6'd6: begin
        r = (e.aluctl == 6'd2) ? sx + sy : sx - sy;
        e.result   = r[31:0];
        e.overflow = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      default: e.result = 32'd0;
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  task automatic send(input logic rst_n, input logic v, input logic [5:0] op,
                      input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    reset_n  = rst_n;
    in_valid = v;
    opcode   = op;
    funct    = fn;
    a        = x;
    b        = y;
    model_q  = model(model_q, rst_n, v, op, fn, x, y);
    sb.push_back(model_q);
  endtask

  // Monitor: one expectation per clock, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_valid", {31'd0, out_valid}, {31'd0, e.out_valid});
        chk("flags", {23'd0, regdst, branch_eq, branch_ne, memread, memwrite,
                      memtoreg, alusrc, regwrite, jump}, {23'd0, e.flags});
        chk("aluop_aluctl", {24'd0, aluop, aluctl}, {24'd0, e.aluop, e.aluctl});
        chk("result", result, e.result);
        chk("zero_ovf", {30'd0, zero, overflow}, {30'd0, e.zero, e.overflow});
      end
    end
  end

  initial begin
    logic [5:0] ops [10];
    logic [5:0] fns [8];
    logic [5:0] op_r, fn_r;
    ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h02, 6'h3f};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h26, 6'h11};
    model_q = '0;

    // Reset with a valid input present: must be ignored.
    send(1'b0, 1'b1, 6'h00, 6'h20, 32'd1, 32'd2);
    send(1'b0, 1'b0, 6'h00, 6'h00, 32'd0, 32'd0);
    // First valid after reset, then directed cases.
    send(1'b1, 1'b1, 6'h00, 6'h20, 32'd5, 32'd7);
    send(1'b1, 1'b1, 6'h04, 6'h00, 32'h1234, 32'h1234);
    send(1'b1, 1'b1, 6'h05, 6'h00, 32'h1234, 32'h1235);
    send(1'b1, 1'b1, 6'h00, 6'h2a, 32'hFFFFFFFF, 32'd1);
    send(1'b1, 1'b1, 6'h00, 6'h2a, 32'h7FFFFFFF, 32'h80000000);
    send(1'b1, 1'b1, 6'h00, 6'h20, 32'h7FFFFFFF, 32'd1);
    send(1'b1, 1'b1, 6'h00, 6'h22, 32'h80000000, 32'd1);
    send(1'b1, 1'b1, 6'h23, 6'h00, 32'h100, 32'h4);
    send(1'b1, 1'b1, 6'h3f, 6'h00, 32'd3, 32'd4);
    send(1'b1, 1'b0, 6'h00, 6'h22, 32'd9, 32'd9);
    send(1'b1, 1'b0, 6'h2b, 6'h00, 32'd1, 32'd1);
    send(1'b1, 1'b1, 6'h00, 6'h27, 32'h0F0F0000, 32'h000000F0);
    send(1'b1, 1'b1, 6'h00, 6'h26, 32'hAAAA5555, 32'hFFFF0000);
    send(1'b1, 1'b1, 6'h00, 6'h25, 32'h00F0, 32'h0F00);
    send(1'b1, 1'b1, 6'h00, 6'h24, 32'hFF00FF00, 32'h0FF00FF0);
    send(1'b1, 1'b1, 6'h00, 6'h3f, 32'hFFFFFFFF, 32'hFFFFFFFF);
    send(1'b1, 1'b1, 6'h02, 6'h00, 32'd10, 32'd20);
    send(1'b1, 1'b1, 6'h08, 6'h00, 32'hFFFFFFFF, 32'd1);
    // Three back-to-back valids with reset in the middle one.
    send(1'b1, 1'b1, 6'h00, 6'h20, 32'd100, 32'd200);
    send(1'b0, 1'b1, 6'h00, 6'h22, 32'd50, 32'd8);
    send(1'b1, 1'b1, 6'h00, 6'h25, 32'h30, 32'h0C);
    send(1'b1, 1'b0, 6'h00, 6'h00, 32'd0, 32'd0);

    for (int i = 0; i < 80; i++) begin
      op_r = ops[$urandom_range(0, 9)];
      fn_r = fns[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) op_r = 6'($urandom);
      send(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) != 0), op_r, fn_r,
           (($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : 32'($urandom)),
           (($urandom_range(0, 3) == 0) ? 32'h80000000 : 32'($urandom)));
    end
    send(1'b1, 1'b0, 6'h00, 6'h00, 32'd0, 32'd0);

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
